// File: rtl/fft_result_unloader_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants and types for the FFT result unloader:
//   FFT_NPTS  bins per frame (power of two)
//   FFT_DW    bits per real/imaginary component
//   FFT_IDXW  bits of a bin index, log2(FFT_NPTS)
//   cplx_t    one stored complex bin {x, y}
//   rd_state_t read-side FSM states
//   bitrev_idx reverses the bits of a bin index
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_NPTS = 16;
    localparam int FFT_DW   = 17;
    localparam int FFT_IDXW = 4;

    localparam logic [FFT_IDXW-1:0] FFT_IDX_ZERO = 4'd0;
    localparam logic [FFT_IDXW-1:0] FFT_IDX_ONE  = 4'd1;
    localparam logic [FFT_IDXW-1:0] FFT_IDX_LAST = 4'd15;

    typedef struct packed {
        logic signed [FFT_DW-1:0] x;
        logic signed [FFT_DW-1:0] y;
    } cplx_t;

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    // Mirror the index bits: bit i of k lands on bit FFT_IDXW-1-i.
    function automatic logic [FFT_IDXW-1:0] bitrev_idx(input logic [FFT_IDXW-1:0] k);
        logic [FFT_IDXW-1:0] r;
        r = {FFT_IDXW{1'b0}};
        for (int i = 0; i < FFT_IDXW; i++) begin
            r[FFT_IDXW-1-i] = k[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_result_unloader_if.sv
// -----------------------------------------------------------------------------
// fft_unload_if
// Bundles the frame-capture side and the beat-stream side of the unloader.
//   frame_valid/frame_ready  frame handshake, frame_x/frame_y packed bins
//   out_valid/out_ready      beat handshake, out_x/out_y/out_index/out_last
//   overrun                  sticky "frame offered while not ready"
// Modports: slave = the unloader, master = producer/consumer environment.
// -----------------------------------------------------------------------------
interface fft_unload_if;
    import fft_pkg::*;

    logic                         frame_valid;
    logic                         frame_ready;
    logic [FFT_NPTS*FFT_DW-1:0]   frame_x;
    logic [FFT_NPTS*FFT_DW-1:0]   frame_y;
    logic                         out_valid;
    logic                         out_ready;
    logic [FFT_DW-1:0]            out_x;
    logic [FFT_DW-1:0]            out_y;
    logic [FFT_IDXW-1:0]          out_index;
    logic                         out_last;
    logic                         overrun;

    modport slave (
        input  frame_valid, frame_x, frame_y, out_ready,
        output frame_ready, out_valid, out_x, out_y, out_index, out_last, overrun
    );

    modport master (
        output frame_valid, frame_x, frame_y, out_ready,
        input  frame_ready, out_valid, out_x, out_y, out_index, out_last, overrun
    );

endinterface

// File: rtl/fft_result_unloader_bank.sv
// -----------------------------------------------------------------------------
// fft_unload_bank
// One frame of storage: FFT_NPTS complex bins written all at once, read one
// bin at a time through a combinational indexed port.
// Ports:
//   clock, reset_n   clock and async active-low reset (clears every bin)
//   i_we             capture i_frame_x / i_frame_y into the bank this edge
//   i_frame_x/y      packed frame, bin k at [k*FFT_DW +: FFT_DW]
//   i_rd_addr        bin to present on o_rd
//   o_rd             stored bin at i_rd_addr
// -----------------------------------------------------------------------------
module fft_unload_bank
    import fft_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       i_we,
    input  logic [FFT_NPTS*FFT_DW-1:0] i_frame_x,
    input  logic [FFT_NPTS*FFT_DW-1:0] i_frame_y,
    input  logic [FFT_IDXW-1:0]        i_rd_addr,
    output cplx_t                      o_rd
);

    cplx_t r_mem [FFT_NPTS];

    // Parallel capture of a whole frame; cleared on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < FFT_NPTS; k++) begin
                r_mem[k] <= {(2*FFT_DW){1'b0}};
            end
        end else if (i_we) begin
            for (int k = 0; k < FFT_NPTS; k++) begin
                r_mem[k].x <= i_frame_x[k*FFT_DW +: FFT_DW];
                r_mem[k].y <= i_frame_y[k*FFT_DW +: FFT_DW];
            end
        end
    end

    assign o_rd = r_mem[i_rd_addr];

endmodule

// File: rtl/fft_result_unloader.sv
// -----------------------------------------------------------------------------
// fft_result_unloader
// Captures a complete FFT result frame in one cycle into one of two ping-pong
// banks and streams it out one bin per beat on a valid/ready interface.
// Ports:
//   clock     rising-edge clock
//   reset_n   asynchronous active-low reset
//   bus       fft_unload_if.slave: frame_valid/ready, frame_x/y, out_valid/
//             ready, out_x/y, out_index, out_last, overrun
// Build option:
//   FFT_UNLOAD_BITREV_EN  beat k reads stored bin bitrev(k) so a bit-reversed
//                         core output leaves in natural order; out_index
//                         still reports k. Undefined: beat k reads bin k.
// -----------------------------------------------------------------------------
module fft_result_unloader
    import fft_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    fft_unload_if.slave  bus
);

    rd_state_t           r_state;
    logic [FFT_IDXW-1:0] r_cnt;
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic                r_overrun;

    logic                w_frame_ready;
    logic                w_capture;
    logic                w_blocked;
    logic                w_beat;
    logic                w_done;
    logic                w_other_bank;
    logic [1:0]          w_full_nxt;
    logic [FFT_IDXW-1:0] w_rd_addr;
    cplx_t               w_rd_b0;
    cplx_t               w_rd_b1;
    cplx_t               w_rd;

    // Readiness depends only on registered flags, so a bank freed at an edge
    // becomes writable one cycle later.
    assign w_frame_ready = ~r_full[r_wr_bank];
    assign w_capture     = bus.frame_valid & w_frame_ready;
    assign w_blocked     = bus.frame_valid & ~w_frame_ready;
    assign w_beat        = (r_state == RD_STREAM) & bus.out_ready;
    assign w_done        = w_beat & (r_cnt == FFT_IDX_LAST);
    assign w_other_bank  = ~r_rd_bank;

    // Next full flags. A capture always targets an empty bank and a completion
    // always frees the full bank being read, so the two never collide.
    always_comb begin
        w_full_nxt = r_full;
        if (w_capture) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end else begin
            w_full_nxt[r_wr_bank] = r_full[r_wr_bank];
        end
        if (w_done) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end else begin
            w_full_nxt[r_rd_bank] = w_full_nxt[r_rd_bank];
        end
    end

    // Bank pointers, flags, overrun and the read-side beat FSM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= RD_IDLE;
            r_cnt     <= FFT_IDX_ZERO;
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_capture) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_blocked) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                RD_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_state <= RD_STREAM;
                        r_cnt   <= FFT_IDX_ZERO;
                    end
                end
                RD_STREAM: begin
                    if (w_beat) begin
                        if (r_cnt == FFT_IDX_LAST) begin
                            r_rd_bank <= w_other_bank;
                            r_cnt     <= FFT_IDX_ZERO;
                            // Continue without a bubble only if the next
                            // frame was already sitting in the other bank.
                            if (!r_full[w_other_bank]) begin
                                r_state <= RD_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + FFT_IDX_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= RD_IDLE;
                    r_cnt   <= FFT_IDX_ZERO;
                end
            endcase
        end
    end

`ifdef FFT_UNLOAD_BITREV_EN
    assign w_rd_addr = bitrev_idx(r_cnt);
`else
    assign w_rd_addr = r_cnt;
`endif

    fft_unload_bank u_bank0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_we      (w_capture & ~r_wr_bank),
        .i_frame_x (bus.frame_x),
        .i_frame_y (bus.frame_y),
        .i_rd_addr (w_rd_addr),
        .o_rd      (w_rd_b0)
    );

    fft_unload_bank u_bank1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_we      (w_capture & r_wr_bank),
        .i_frame_x (bus.frame_x),
        .i_frame_y (bus.frame_y),
        .i_rd_addr (w_rd_addr),
        .o_rd      (w_rd_b1)
    );

    assign w_rd = r_rd_bank ? w_rd_b1 : w_rd_b0;

    // Every output is a function of registers only; data is bit-exact.
    assign bus.frame_ready = w_frame_ready;
    assign bus.out_valid   = (r_state == RD_STREAM);
    assign bus.out_last    = (r_state == RD_STREAM) & (r_cnt == FFT_IDX_LAST);
    assign bus.out_index   = r_cnt;
    assign bus.out_x       = w_rd.x;
    assign bus.out_y       = w_rd.y;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_fft_result_unloader.sv
// -----------------------------------------------------------------------------
// tb_fft_result_unloader
// Drives frames and consumer back-pressure into fft_result_unloader and checks
// every cycle against a frame-queue model, plus hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_fft_result_unloader;

    localparam int NP = 16;
    localparam int DW = 17;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    fft_unload_if bus ();

    fft_result_unloader dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Beat order expected from frame bin k = k+1.
`ifdef FFT_UNLOAD_BITREV_EN
    int sf_exp [16] = '{1, 9, 5, 13, 3, 11, 7, 15, 2, 10, 6, 14, 4, 12, 8, 16};
`else
    int sf_exp [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
`endif

    int vec [16] = '{640, 122, -226, -303, -64, 191, 12, -88,
                     0, 65535, -65536, 7, -1, 300, -450, 33};

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [3:0]    idx;
        logic          last;
        int            avail;
    } beat_t;

    beat_t q [$];
    int    held  = 0;
    logic  ovr_m = 1'b0;
    int    cyc   = 0;

    function automatic int src_bin(input int k);
`ifdef FFT_UNLOAD_BITREV_EN
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            if (((k >> i) & 1) != 0) r = r | (1 << (3 - i));
        end
        return r;
`else
        return k;
`endif
    endfunction

    // Compare DUT outputs with the model, then advance the model across the
    // coming rising edge using the (stable) inputs.
    always @(negedge clock) begin : mon
        logic  ev;
        logic  rdy;
        beat_t b;
        if (!reset_n) begin
            q.delete();
            held  = 0;
            ovr_m = 1'b0;
            cyc   = 0;
        end else begin
            ev  = (q.size() > 0) && (cyc >= q[0].avail);
            rdy = (held < 2);
            check("mon_out_valid", 64'(bus.out_valid), 64'(ev));
            check("mon_frame_ready", 64'(bus.frame_ready), 64'(rdy));
            check("mon_overrun", 64'(bus.overrun), 64'(ovr_m));
            if (ev) begin
                check("mon_out_x", 64'(bus.out_x), 64'(q[0].x));
                check("mon_out_y", 64'(bus.out_y), 64'(q[0].y));
                check("mon_out_index", 64'(bus.out_index), 64'(q[0].idx));
                check("mon_out_last", 64'(bus.out_last), 64'(q[0].last));
            end
            if (bus.frame_valid && !rdy) ovr_m = 1'b1;
            if (ev && bus.out_ready) begin
                if (q[0].last) held--;
                void'(q.pop_front());
            end
            if (bus.frame_valid && rdy) begin
                for (int k = 0; k < NP; k++) begin
                    b.x     = bus.frame_x[src_bin(k)*DW +: DW];
                    b.y     = bus.frame_y[src_bin(k)*DW +: DW];
                    b.idx   = 4'(k);
                    b.last  = (k == NP - 1);
                    b.avail = cyc + 2;
                    q.push_back(b);
                end
                held++;
            end
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [NP*DW-1:0] fx, input logic [NP*DW-1:0] fy);
        bus.frame_x     = fx;
        bus.frame_y     = fy;
        bus.frame_valid = 1'b1;
        step();
        bus.frame_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.out_ready = 1'b1;
        while ((q.size() != 0) && (n < 400)) begin
            step();
            n++;
        end
        check(name, 64'(q.size() == 0), 64'd1);
        step();
    endtask

    function automatic logic [NP*DW-1:0] ramp_frame();
        logic [NP*DW-1:0] f;
        for (int k = 0; k < NP; k++) f[k*DW +: DW] = DW'(k + 1);
        return f;
    endfunction

    function automatic logic [NP*DW-1:0] rand_frame();
        logic [NP*DW-1:0] f;
        for (int k = 0; k < NP; k++) f[k*DW +: DW] = DW'($urandom);
        return f;
    endfunction

    logic [NP*DW-1:0] zero_frame;

    initial begin
        int acc;
        int n;
        zero_frame      = {(NP*DW){1'b0}};
        bus.frame_valid = 1'b0;
        bus.frame_x     = zero_frame;
        bus.frame_y     = zero_frame;
        bus.out_ready   = 1'b0;

        // Reset state.
        #1 reset_n = 1'b0;
        #2;
        check("rst_frame_ready", 64'(bus.frame_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_out_index", 64'(bus.out_index), 64'd0);
        check("rst_out_x", 64'(bus.out_x), 64'd0);
        check("rst_out_y", 64'(bus.out_y), 64'd0);
        check("rst_overrun", 64'(bus.overrun), 64'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Single ramp frame, consumer always ready.
        bus.out_ready = 1'b1;
        offer(ramp_frame(), zero_frame);
        check("sf_latency_edge0", 64'(bus.out_valid), 64'd0);
        step();
        for (int k = 0; k < NP; k++) begin
            check("sf_valid", 64'(bus.out_valid), 64'd1);
            check("sf_x", 64'(bus.out_x), 64'(sf_exp[k]));
            check("sf_y", 64'(bus.out_y), 64'd0);
            check("sf_index", 64'(bus.out_index), 64'(k));
            check("sf_last", 64'(bus.out_last), 64'(k == NP - 1));
            step();
        end
        check("sf_end_valid", 64'(bus.out_valid), 64'd0);
        drain("sf_drain");

        // Signed vector, exact sign-extended pass-through.
        begin
            logic [NP*DW-1:0] fx;
            for (int k = 0; k < NP; k++) fx[k*DW +: DW] = DW'(vec[k]);
            offer(fx, zero_frame);
            step();
            check("vec_beat0_x", 64'(bus.out_x), 64'(17'h00280));
            check("vec_beat0_valid", 64'(bus.out_valid), 64'd1);
            drain("vec_drain");
        end

        // Back-pressure: out_ready toggles every cycle.
        bus.out_ready = 1'b0;
        offer(rand_frame(), rand_frame());
        acc = 0;
        n   = 0;
        while ((acc < NP) && (n < 100)) begin
            bus.out_ready = ~bus.out_ready;
            if (bus.out_valid && bus.out_ready) acc++;
            step();
            n++;
        end
        check("bp_beats", 64'(acc), 64'(NP));
        bus.out_ready = 1'b0;
        step();
        check("bp_no_extra", 64'(bus.out_valid), 64'd0);
        drain("bp_drain");

        // Ping-pong: three offers while the consumer is stalled.
        bus.out_ready   = 1'b0;
        bus.frame_valid = 1'b1;
        bus.frame_x     = rand_frame();
        bus.frame_y     = rand_frame();
        step();
        bus.frame_x = rand_frame();
        bus.frame_y = rand_frame();
        step();
        bus.frame_x = rand_frame();
        bus.frame_y = rand_frame();
        check("pp_ready_low", 64'(bus.frame_ready), 64'd0);
        check("pp_overrun_before", 64'(bus.overrun), 64'd0);
        step();
        bus.frame_valid = 1'b0;
        check("pp_overrun_set", 64'(bus.overrun), 64'd1);
        step();
        check("pp_ready_still_low", 64'(bus.frame_ready), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2 * NP; i++) begin
            check("pp_valid", 64'(bus.out_valid), 64'd1);
            check("pp_last", 64'(bus.out_last), 64'((i == NP - 1) || (i == 2 * NP - 1)));
            step();
        end
        check("pp_end_valid", 64'(bus.out_valid), 64'd0);
        check("pp_overrun_sticky", 64'(bus.overrun), 64'd1);
        drain("pp_drain");

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            bus.frame_valid = ($urandom_range(0, 3) == 0);
            bus.frame_x     = rand_frame();
            bus.frame_y     = rand_frame();
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.frame_valid = 1'b0;
        drain("rnd_drain");

        // Reset in the middle of a frame.
        bus.out_ready = 1'b1;
        offer(ramp_frame(), ramp_frame());
        n = 0;
        while (!(bus.out_valid && (bus.out_index == 4'd7)) && (n < 50)) begin
            step();
            n++;
        end
        check("mr_reached_beat7", 64'(bus.out_index), 64'd7);
        #2 reset_n = 1'b0;
        #1;
        check("mr_out_valid", 64'(bus.out_valid), 64'd0);
        check("mr_out_last", 64'(bus.out_last), 64'd0);
        check("mr_out_index", 64'(bus.out_index), 64'd0);
        check("mr_out_x", 64'(bus.out_x), 64'd0);
        check("mr_out_y", 64'(bus.out_y), 64'd0);
        check("mr_overrun", 64'(bus.overrun), 64'd0);
        check("mr_frame_ready", 64'(bus.frame_ready), 64'd1);
        step();
        step();
        reset_n = 1'b1;
        step();
        offer(ramp_frame(), zero_frame);
        check("mr2_latency", 64'(bus.out_valid), 64'd0);
        step();
        check("mr2_valid", 64'(bus.out_valid), 64'd1);
        check("mr2_index0", 64'(bus.out_index), 64'd0);
        check("mr2_x0", 64'(bus.out_x), 64'(sf_exp[0]));
        drain("mr2_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_result_unloader.md
# fft_result_unloader

Output-side companion to the 16-point CORDIC FFT core (`fft1`): captures one complete 16-bin result frame (17-bit real/imaginary per bin) in a single cycle and streams it out one bin per beat over a valid/ready interface. Two-bank ping-pong storage lets the next frame be captured while the current one drains. Sits between `fft1` and any serial consumer, such as a magnitude unit, a FIFO or a bus bridge.

## Interface
- `NPTS`, 16, bins per frame; must be a power of two.
- `DW`, 17, bits per real/imaginary component, matching the `fft1` output width.
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `frame_valid` input 1: a result frame is present on `frame_x` / `frame_y`.
- `frame_ready` output 1: a frame will be captured this cycle if `frame_valid` is high.
- `frame_x` input NPTS*DW: real parts; bin k occupies `[k*DW +: DW]`.
- `frame_y` input NPTS*DW: imaginary parts, same packing as `frame_x`.
- `out_valid` output 1: `out_*` carries a valid bin.
- `out_ready` input 1: consumer accepts the current beat.
- `out_x` output DW: real part of the current bin.
- `out_y` output DW: imaginary part of the current bin.
- `out_index` output log2(NPTS): bin number of the current beat.
- `out_last` output 1: high on the final beat (beat NPTS-1) of a frame.
- `overrun` output 1: sticky; set when `frame_valid` is high and `frame_ready` is low.

## Operation
- Storage: two banks (B0, B1), each holding NPTS × {x, y}. Each bank has a `full` flag.
- Write pointer `wr_bank` starts at B0.
  - `frame_ready` = !full[wr_bank].
  - On capture: the whole frame is written to `wr_bank`, `full[wr_bank]` is set, and `wr_bank` toggles.
- Read side FSM has two states:
  - IDLE: `out_valid` = 0. If full[rd_bank] is set, go to STREAM with beat counter `cnt` = 0.
  - STREAM: `out_valid` = 1. On each accepted beat (`out_valid` && `out_ready`), `cnt` increments.
  - On the accepted beat with `cnt` = NPTS-1: clear full[rd_bank] and toggle `rd_bank`. If the other bank is already full, stay in STREAM with `cnt` = 0 (back-to-back frames, no bubble). Otherwise go to IDLE.
- `out_index` = `cnt` (see Configuration for the storage address actually read).
- `out_x` / `out_y` are a mux of bank registers addressed by the registered `rd_bank` / `cnt`. No arithmetic is applied; data passes through bit-exact.
- `out_*` must hold stable while `out_valid` && !`out_ready`.
- `overrun` is sticky and cleared only by reset. A frame offered while not ready is not captured.

## Timing
- Reset values:
  - `frame_ready` = 1, `out_valid` = 0, `out_last` = 0, `out_index` = 0, `out_x` = `out_y` = 0, `overrun` = 0.
  - Banks are cleared, both flags are empty, `rd_bank` = `wr_bank` = B0, FSM is in IDLE.
- Latency: a frame captured at edge N gives `out_valid` high from edge N+1 (one cycle), provided the reader was IDLE.
- Throughput: one bin per cycle while `out_ready` = 1. Two back-to-back frames take 32 consecutive beats.
- Simultaneous events:
  - `frame_ready` is derived from registered flags only. If a bank is freed at edge N, capture into it is possible from cycle N+1 at the earliest, never in the same cycle.
  - Capture and a read completion in the same cycle are both honoured.
- Reset asserted mid-frame: all state is lost immediately and asynchronously, and outputs return to their reset values.

## Configuration
- `FFT_UNLOAD_BITREV_EN` defined: beat k reads stored bin bitrev(k) over log2(NPTS) bits. This restores natural order from a bit-reversed core output. `out_index` still reports k.
- Not defined: beat k reads stored bin k (natural pass-through).

## Structure
- Package `fft_pkg` holds:
  - the constants `FFT_NPTS` = 16, `FFT_DW` = 17 and `FFT_IDXW` = 4;
  - a typedef for the complex sample {x, y};
  - the function `bitrev_idx`.
- One sub-module, `fft_unload_bank`: an NPTS-entry register bank with a parallel write port and one combinational indexed read port. It is instantiated twice.

## Test plan
- Single frame: `frame_x` bin k = k+1, `frame_y` = 0, `out_ready` tied high. Expect `out_valid` one cycle after capture, then beats 1..16 in order, `out_last` on beat 16, then `out_valid` = 0.
- The `fft1` bench vector (x = 640, 122, −226, …, all y = 0) applied as a frame → each output beat equals the corresponding input bin exactly, with sign-extended 17-bit values.
- Back-pressure: toggle `out_ready` every other cycle. Output must hold stable during stalls and the 16 beats must be delivered without loss or duplication.
- Ping-pong: offer three frames with `out_ready` = 0.
  - Frames 1 and 2 are captured, then `frame_ready` = 0 and `overrun` = 1.
  - Release `out_ready`: 32 beats are delivered with no gap, and `out_last` appears on beats 16 and 32.
- With `FFT_UNLOAD_BITREV_EN`, bin k = k: expect beat sequence 0, 8, 4, 12, 2, … and `out_index` 0..15.
- Assert `reset_n` low at beat 7 → all outputs are at their reset values immediately. After release, a new frame streams correctly from beat 0.
